// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the ME-stage data bus.
// Stores to TXDATA queue bytes in a small circular FIFO; loads from STATUS poll it.
// A one-process FSM drains the FIFO onto TxD, LSB first, with a registered line output.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxD,
    output logic        Busy
);

    // Pointer width; pointers wrap naturally because the depth is a power of two.
    localparam int AW = $clog2(FIFO_DEPTH);
    // Baud counter width; it only ever needs to reach CLKS_PER_BIT-1.
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [29:0]   TX_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0]   ST_WORD   = BASE_ADDR[31:2] + 30'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    // Transmitter state
    state_t        r_state;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;

    // Decode and handshake wires
    logic          w_sel_tx;
    logic          w_sel_st;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_wr_tx;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_baud_last;
    logic [4:0]    w_count_ext;
    logic [31:0]   w_status;
    logic          w_unused;

    // Word decode: byte offset within the word is don't-care.
    assign w_sel_tx = (Address[31:2] == TX_WORD);
    assign w_sel_st = (Address[31:2] == ST_WORD);
    assign Hit      = w_sel_tx | w_sel_st;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // The FSM takes the head only while idle, so a pop frees a slot in the same edge.
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_wr_tx   = MemWrite && w_sel_tx;
    assign w_push    = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_set = w_wr_tx && !w_push;
    assign w_ovf_clr = MemWrite && w_sel_st && WriteData[3];

    assign w_baud_last = (r_baud == BAUD_LAST);

    // The count field is four bits wide; deeper FIFOs only report the low bits.
    assign w_count_ext = 5'(r_count);
    assign w_status    = {24'b0, w_count_ext[3:0], r_ovf, (r_state != S_IDLE), w_empty, w_full};

    assign TxD  = r_txd;
    assign Busy = (r_state != S_IDLE) || !w_empty;

    // Bits that are intentionally not looked at.
    assign w_unused = ^{Address[1:0], WriteData[31:8], w_count_ext[4]};

    // Combinational load path, same timing as a data-memory read.
    always_comb begin
        ReadData = 32'b0;
        if (MemRead && w_sel_st) begin
            ReadData = w_status;
        end
    end

    // FIFO payload; the pointers/count carry the emptied-on-reset state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serial framing FSM: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= 3'd0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            // Next bit is shift[1] now, shift[0] after the shift lands.
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: bus stores push expected bytes into a scoreboard; a serial
// monitor decodes TxD frames and compares each byte against the queue head.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1001_0040;
    localparam logic [31:0] STAT = BASE + 32'd4;
    localparam int          CPB  = 4;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic        TxD;
    logic        Busy;

    int          n_chk;
    int          n_err;
    logic [7:0]  sb[$];

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .TxD       (TxD),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the store edge.
    task automatic wr_bus(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic wr_tx(input logic [31:0] data, input bit acc);
        if (acc) sb.push_back(data[7:0]);
        wr_bus(BASE, data);
    endtask

    // Combinational read in the current half cycle; no clock advance.
    task automatic rd_status(output logic [31:0] d);
        Address = STAT;
        MemRead = 1'b1;
        #1 d = ReadData;
        MemRead = 1'b0;
    endtask

    // Serial monitor: samples mid-bit on negedges; frames hit by reset are dropped.
    initial begin : mon
        logic [7:0]  b;
        logic [31:0] e;
        logic        st;
        logic        sp;
        bit          ab;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && TxD === 1'b0) begin
                ab = 0;
                repeat (2) @(negedge clk);
                ab |= !reset;
                st = TxD;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    ab |= !reset;
                    b[i] = TxD;
                end
                repeat (CPB) @(negedge clk);
                ab |= !reset;
                sp = TxD;
                if (!ab) begin
                    chk("mon_start", {31'b0, st}, 32'd0);
                    chk("mon_stop", {31'b0, sp}, 32'd1);
                    e = (sb.size() == 0) ? 32'h100 : {24'b0, sb.pop_front()};
                    chk("mon_byte", {24'b0, b}, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] st;
        logic [9:0]  seq;
        logic [7:0]  bytes [5];
        bit          found;
        bit          bad;

        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        Address = 32'b0;
        WriteData = 32'b0;
        MemWrite = 1'b0;
        MemRead = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'b0, TxD}, 32'd1);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        rd_status(st);
        chk("rst_status", st, 32'h0000_0002);

        // 2: single byte 0x55, exact bit timing
        wr_tx(32'hFFFF_FF55, 1);
        chk("t2_latency", {31'b0, TxD}, 32'd1);
        seq = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            chk("t2_txd", {31'b0, TxD}, {31'b0, seq[k / CPB]});
            if (k == 10 * CPB - 1) chk("t2_busy_hi", {31'b0, Busy}, 32'd1);
        end
        @(negedge clk);
        chk("t2_busy_lo", {31'b0, Busy}, 32'd0);

        // 3: fill and overflow
        bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h81;
        bytes[3] = 8'h7E; bytes[4] = 8'h01;
        for (int i = 0; i < 5; i++) wr_tx({24'hABCDEF, bytes[i]}, 1);
        rd_status(st);
        chk("t3_full_status", st, 32'h0000_0045);
        wr_tx(32'h0000_00EE, 0);
        rd_status(st);
        chk("t3_ovf_status", st, 32'h0000_004D);

        // 5a: overflow clear needs bit 3
        wr_bus(STAT, 32'hFFFF_FFF7);
        rd_status(st);
        chk("t5_ovf_kept", st, 32'h0000_004D);
        wr_bus(STAT, 32'h0000_0008);
        rd_status(st);
        chk("t5_ovf_clr", st, 32'h0000_0045);

        // 4: store on the IDLE-pop cycle while full
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            rd_status(st);
            if (!st[2]) found = 1;
            else @(negedge clk);
        end
        chk("t4_idle_seen", {31'b0, found}, 32'd1);
        chk("t4_idle_status", st, 32'h0000_0041);
        wr_tx(32'h1234_5696, 1);
        rd_status(st);
        chk("t4_after", st, 32'h0000_0045);

        // 5b: decode
        Address = BASE + 32'd8;
        WriteData = 32'h0000_0077;
        MemWrite = 1'b1;
        #1 chk("t5_hit_plus8", {31'b0, Hit}, 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        rd_status(st);
        chk("t5_nochange", st, 32'h0000_0045);
        Address = BASE + 32'd3;
        #1 chk("t5_hit_tx_lo", {31'b0, Hit}, 32'd1);
        Address = BASE + 32'd7;
        #1 chk("t5_hit_st_lo", {31'b0, Hit}, 32'd1);
        Address = BASE - 32'd4;
        #1 chk("t5_hit_minus4", {31'b0, Hit}, 32'd0);
        Address = BASE;
        MemRead = 1'b1;
        #1 chk("t5_rd_txdata", ReadData, 32'd0);
        MemRead = 1'b0;
        Address = STAT;
        #1 chk("t5_rd_noread", ReadData, 32'd0);

        // drain everything accepted so far
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (!Busy) found = 1;
        end
        chk("drain_done", {31'b0, found}, 32'd1);
        chk("drain_sb", 32'(sb.size()), 32'd0);
        rd_status(st);
        chk("drain_status", st, 32'h0000_0002);

        // 6: reset during data bit 3 of 0xA5 (bit 3 is 0)
        wr_tx(32'h0000_00A5, 1);
        repeat (18) @(negedge clk);
        chk("t6_pre_txd", {31'b0, TxD}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("t6_txd_async", {31'b0, TxD}, 32'd1);
        chk("t6_busy_async", {31'b0, Busy}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Busy !== 1'b0) bad = 1;
        end
        chk("t6_no_residual", {31'b0, bad}, 32'd0);
        rd_status(st);
        chk("t6_status", st, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
